// File: rtl/prog_imem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : prog_imem_pkg
//  Description : Shared types and constants for the instruction memory with
//                its serial byte-stream program loader.
//  Revision    : 1.0 - initial release
// ============================================================================
package prog_imem_pkg;

    // Loader session states
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR0 = 3'd1,
        ST_HDR1 = 3'd2,
        ST_DATA = 3'd3,
        ST_DONE = 3'd4
    } prog_state_t;

    // Length header: low byte then high byte, length counted in words
    localparam int HDR_BYTES = 2;

    // RISC-V "addi x0, x0, 0" returned for fetches outside the array
    localparam logic [31:0] DEFAULT_NOP = 32'h0000_0013;

endpackage
`default_nettype wire

// File: rtl/prog_imem_byte_packer.sv
`default_nettype none
// ============================================================================
//  Module      : byte_packer
//  Description : Packs a byte stream little-endian into XLEN-bit words. The
//                completed word and its strobe are presented combinationally
//                in the same cycle the final byte is offered, so the consumer
//                can write it on the accepting edge.
//  Revision    : 1.0 - initial release
// ============================================================================
import prog_imem_pkg::*;

module byte_packer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            in_valid,
    input  logic [7:0]      in_byte,
    output logic [XLEN-1:0] word,
    output logic            word_ready
);

    localparam int NB = XLEN / 8;

    generate
        if (NB > 1) begin : g_multi
            localparam int CNT_W = $clog2(NB);

            logic [CNT_W-1:0] r_cnt;
            logic [XLEN-9:0]  r_lo;
            logic             w_last;

            assign w_last = (r_cnt == CNT_W'(NB - 1));

            // Byte position within the word being assembled; clear drops a partial word
            always_ff @(posedge clk) begin
                if (!rst_n || clr) begin
                    r_cnt <= '0;
                end else if (in_valid) begin
                    r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
                end
            end

            // Hold all but the final byte; stale lanes are always overwritten before use
            always_ff @(posedge clk) begin
                if (!clr && in_valid && !w_last) begin
                    r_lo[8*r_cnt +: 8] <= in_byte;
                end
            end

            assign word       = {in_byte, r_lo};
            assign word_ready = in_valid & ~clr & w_last;
        end else begin : g_single
            logic w_unused_ctrl;

            assign w_unused_ctrl = clk ^ rst_n;
            assign word          = in_byte;
            assign word_ready    = in_valid & ~clr;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/prog_imem.sv
`default_nettype none
// ============================================================================
//  Module      : prog_imem
//  Description : Instruction memory with combinational fetch port and a
//                length-prefixed serial program loader that stalls the core
//                for the duration of a load session.
//  Revision    : 1.0 - initial release
// ============================================================================
import prog_imem_pkg::*;

module prog_imem #(
    parameter int              MEM_DEPTH = 1024,
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] NOP_WORD  = XLEN'(DEFAULT_NOP)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [31:0]                address,
    output logic [XLEN-1:0]            instruction,
    input  logic [7:0]                 rx_data,
    input  logic                       rx_valid,
    output logic                       rx_ready,
    input  logic                       prog_start,
    output logic                       cpu_stall,
    output logic                       prog_done,
    output logic                       prog_err,
    output logic [$clog2(MEM_DEPTH):0] word_count
);

    localparam int ADDR_W = $clog2(MEM_DEPTH);
    localparam int CNT_W  = ADDR_W + 1;

    logic [XLEN-1:0]  r_mem [MEM_DEPTH];
    prog_state_t      r_state;
    logic [7:0]       r_len_lo;
    logic [CNT_W-1:0] r_len;

    logic [15:0]      w_len;
    logic             w_accept;
    logic             w_pack_valid;
    logic             w_pack_clr;
    logic             w_word_ready;
    logic [XLEN-1:0]  w_word;
    logic [CNT_W-1:0] w_count_next;
    logic             w_unused_addr_lsbs;

    // A byte coinciding with prog_start belongs to the aborted session and is dropped
    assign w_accept     = rx_valid & rx_ready & ~prog_start;
    assign w_len        = {rx_data, r_len_lo};
    assign w_pack_valid = w_accept && (r_state == ST_DATA);
    assign w_pack_clr   = prog_start || (r_state != ST_DATA);
    assign w_count_next = word_count + CNT_W'(1);

    byte_packer #(
        .XLEN (XLEN)
    ) u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (w_pack_clr),
        .in_valid   (w_pack_valid),
        .in_byte    (rx_data),
        .word       (w_word),
        .word_ready (w_word_ready)
    );

    // Loader session control with registered handshake and status outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            rx_ready   <= 1'b0;
            cpu_stall  <= 1'b0;
            prog_done  <= 1'b0;
            prog_err   <= 1'b0;
            word_count <= '0;
            r_len_lo   <= '0;
            r_len      <= '0;
        end else begin
            prog_done <= 1'b0;
            if (prog_start) begin
                r_state    <= ST_HDR0;
                rx_ready   <= 1'b1;
                cpu_stall  <= 1'b1;
                prog_err   <= 1'b0;
                word_count <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                    end
                    ST_HDR0: begin
                        if (w_accept) begin
                            r_len_lo <= rx_data;
                            r_state  <= ST_HDR1;
                        end
                    end
                    ST_HDR1: begin
                        if (w_accept) begin
                            if (w_len == 16'd0) begin
                                r_state   <= ST_DONE;
                                rx_ready  <= 1'b0;
                                cpu_stall <= 1'b0;
                                prog_done <= 1'b1;
                            end else if (32'(w_len) > 32'(MEM_DEPTH)) begin
                                r_state   <= ST_IDLE;
                                rx_ready  <= 1'b0;
                                cpu_stall <= 1'b0;
                                prog_err  <= 1'b1;
                            end else begin
                                r_len   <= CNT_W'(w_len);
                                r_state <= ST_DATA;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (w_word_ready) begin
                            word_count <= w_count_next;
                            if (w_count_next == r_len) begin
                                r_state   <= ST_DONE;
                                rx_ready  <= 1'b0;
                                cpu_stall <= 1'b0;
                                prog_done <= 1'b1;
                            end
                        end
                    end
                    ST_DONE: begin
                        r_state <= ST_IDLE;
                    end
                    default: begin
                        r_state   <= ST_IDLE;
                        rx_ready  <= 1'b0;
                        cpu_stall <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Word write on the edge accepting its last byte; array is deliberately not reset
    always_ff @(posedge clk) begin
        if (rst_n && w_pack_valid && w_word_ready) begin
            r_mem[word_count[ADDR_W-1:0]] <= w_word;
        end
    end

    // Combinational fetch; any upper address bit set falls outside the array
    always_comb begin
        instruction = NOP_WORD;
        if (address[31:ADDR_W+2] == '0) begin
            instruction = r_mem[address[ADDR_W+1:2]];
        end
    end

    // Byte offset within a word is irrelevant for word-aligned fetch
    assign w_unused_addr_lsbs = ^address[1:0];

endmodule
`default_nettype wire

// File: tb/tb_prog_imem.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prog_imem
//  Description : Self-checking bench for prog_imem with a word-level memory
//                model built from the byte streams it sends.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_imem;

    localparam int MEM_DEPTH = 1024;
    localparam int XLEN      = 32;
    localparam int AW        = 10;

    logic            clk        = 1'b0;
    logic            rst_n      = 1'b0;
    logic [31:0]     address    = '0;
    logic [XLEN-1:0] instruction;
    logic [7:0]      rx_data    = '0;
    logic            rx_valid   = 1'b0;
    logic            rx_ready;
    logic            prog_start = 1'b0;
    logic            cpu_stall;
    logic            prog_done;
    logic            prog_err;
    logic [AW:0]     word_count;

    int n_checks      = 0;
    int n_fail        = 0;
    int n_done_pulses = 0;

    logic [31:0] m_mem [MEM_DEPTH];
    bit          m_vld [MEM_DEPTH];
    logic [7:0]  q [$];

    prog_imem #(
        .MEM_DEPTH (MEM_DEPTH),
        .XLEN      (XLEN),
        .NOP_WORD  (32'h0000_0013)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .address     (address),
        .instruction (instruction),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .prog_start  (prog_start),
        .cpu_stall   (cpu_stall),
        .prog_done   (prog_done),
        .prog_err    (prog_err),
        .word_count  (word_count)
    );

    always #5 clk = ~clk;

    // Done pulse counter and stall/done exclusivity monitor
    always @(negedge clk) begin
        if (prog_done === 1'b1) n_done_pulses++;
        n_checks++;
        if (prog_done === 1'b1 && cpu_stall === 1'b1) begin
            n_fail++;
            $display("FAIL done_stall_overlap: prog_done=%b cpu_stall=%b required not both 1", prog_done, cpu_stall);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            rx_data = 8'($urandom);
            tick();
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        while (rx_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        n_checks++;
        if (n >= 20) begin
            n_fail++;
            $display("FAIL rx_ready_timeout: rx_ready=%b after %0d cycles, required 1", rx_ready, n);
        end
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic do_start();
        prog_start = 1'b1;
        tick();
        prog_start = 1'b0;
        n_checks++;
        if (cpu_stall !== 1'b1) begin n_fail++; $display("FAIL start_stall: got %b required 1", cpu_stall); end
        n_checks++;
        if (rx_ready !== 1'b1) begin n_fail++; $display("FAIL start_ready: got %b required 1", rx_ready); end
        n_checks++;
        if (prog_err !== 1'b0) begin n_fail++; $display("FAIL start_err_clear: got %b required 0", prog_err); end
        n_checks++;
        if (word_count !== '0) begin n_fail++; $display("FAIL start_count_clear: got %0d required 0", word_count); end
    endtask

    // Full session from prog_start; data bytes taken from q (4 per word)
    task automatic load(input int len, input bit gaps);
        int d0;
        int nb;
        logic [15:0] lv;
        d0 = n_done_pulses;
        lv = 16'(len);
        nb = q.size();
        do_start();
        if (gaps) idle($urandom_range(0, 2));
        send_byte(lv[7:0]);
        if (gaps) idle($urandom_range(0, 2));
        send_byte(lv[15:8]);
        if (len > MEM_DEPTH) begin
            n_checks++;
            if (prog_err !== 1'b1) begin n_fail++; $display("FAIL ovf_err: got %b required 1", prog_err); end
            n_checks++;
            if (rx_ready !== 1'b0 || cpu_stall !== 1'b0 || prog_done !== 1'b0) begin
                n_fail++;
                $display("FAIL ovf_idle: ready=%b stall=%b done=%b required 0 0 0", rx_ready, cpu_stall, prog_done);
            end
            return;
        end
        if (len == 0) begin
            n_checks++;
            if (prog_done !== 1'b1 || cpu_stall !== 1'b0) begin
                n_fail++;
                $display("FAIL zero_len_done: done=%b stall=%b required 1 0", prog_done, cpu_stall);
            end
        end else begin
            for (int k = 1; k <= nb; k++) begin
                if (gaps) idle($urandom_range(0, 2));
                send_byte(q[k-1]);
                n_checks++;
                if (word_count !== 11'(k / 4)) begin
                    n_fail++;
                    $display("FAIL word_count_progress: byte %0d got %0d required %0d", k, word_count, k / 4);
                end
                n_checks++;
                if (k < nb) begin
                    if (cpu_stall !== 1'b1 || prog_done !== 1'b0) begin
                        n_fail++;
                        $display("FAIL stall_in_load: byte %0d stall=%b done=%b required 1 0", k, cpu_stall, prog_done);
                    end
                end else begin
                    if (prog_done !== 1'b1 || cpu_stall !== 1'b0 || rx_ready !== 1'b0) begin
                        n_fail++;
                        $display("FAIL load_end: done=%b stall=%b ready=%b required 1 0 0", prog_done, cpu_stall, rx_ready);
                    end
                end
            end
            for (int w = 0; w < len; w++) begin
                m_mem[w] = {q[4*w+3], q[4*w+2], q[4*w+1], q[4*w]};
                m_vld[w] = 1'b1;
            end
        end
        tick();
        n_checks++;
        if (prog_done !== 1'b0 || rx_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL after_done: done=%b ready=%b required 0 0", prog_done, rx_ready);
        end
        n_checks++;
        if (n_done_pulses - d0 != 1) begin
            n_fail++;
            $display("FAIL done_pulse_count: got %0d required 1", n_done_pulses - d0);
        end
    endtask

    task automatic check_mem();
        for (int i = 0; i < MEM_DEPTH; i++) begin
            if (m_vld[i]) begin
                address = 32'(i * 4) + 32'($urandom_range(0, 3));
                #1;
                n_checks++;
                if (instruction !== m_mem[i]) begin
                    n_fail++;
                    $display("FAIL mem_word[%0d]: got %h required %h", i, instruction, m_mem[i]);
                end
            end
        end
        address = '0;
    endtask

    task automatic fill_random(input int words);
        q.delete();
        for (int i = 0; i < 4 * words; i++) q.push_back(8'($urandom));
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        n_checks++;
        if ({rx_ready, cpu_stall, prog_done, prog_err} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: ready/stall/done/err=%b required 0000", {rx_ready, cpu_stall, prog_done, prog_err});
        end
        n_checks++;
        if (word_count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d required 0", word_count); end
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (rx_ready !== 1'b0 || cpu_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: ready=%b stall=%b required 0 0", rx_ready, cpu_stall);
        end
    endtask

    task automatic test_spec_load();
        q.delete();
        q = {8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h50, 8'h00};
        load(2, 1'b0);
        n_checks++;
        if (word_count !== 11'd2) begin n_fail++; $display("FAIL spec_count: got %0d required 2", word_count); end
        address = 32'h0; #1;
        n_checks++;
        if (instruction !== 32'h00A00513) begin n_fail++; $display("FAIL spec_mem0: got %h required 00a00513", instruction); end
        address = 32'h5; #1;
        n_checks++;
        if (instruction !== 32'h00500593) begin n_fail++; $display("FAIL spec_mem1: got %h required 00500593", instruction); end
    endtask

    task automatic test_fetch_range();
        address = 32'h0001_0000; #1;
        n_checks++;
        if (instruction !== 32'h13) begin n_fail++; $display("FAIL fetch_oor_spec: got %h required 00000013", instruction); end
        address = 32'h0000_1000; #1;
        n_checks++;
        if (instruction !== 32'h13) begin n_fail++; $display("FAIL fetch_oor_edge: got %h required 00000013", instruction); end
        for (int i = 0; i < 6; i++) begin
            address = $urandom | (32'h1 << $urandom_range(12, 31)); #1;
            n_checks++;
            if (instruction !== 32'h13) begin n_fail++; $display("FAIL fetch_oor_rand: addr %h got %h required 00000013", address, instruction); end
        end
        address = '0;
    endtask

    task automatic test_full_depth();
        fill_random(MEM_DEPTH);
        load(MEM_DEPTH, 1'b0);
        check_mem();
    endtask

    task automatic test_len_overflow();
        q.delete();
        load(MEM_DEPTH + 1, 1'b0);
        tick();
        n_checks++;
        if (rx_ready !== 1'b0 || prog_err !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_sticky: ready=%b err=%b required 0 1", rx_ready, prog_err);
        end
        check_mem();
        load($urandom_range(MEM_DEPTH + 2, 65535), 1'b1);
        check_mem();
        q.delete();
        load(0, 1'b0);
        check_mem();
    endtask

    task automatic test_abort();
        do_start();
        send_byte(8'h03);
        send_byte(8'h00);
        fill_random(2);
        for (int k = 0; k < 6; k++) send_byte(q[k]);
        m_mem[0] = {q[3], q[2], q[1], q[0]};
        n_checks++;
        if (word_count !== 11'd1) begin n_fail++; $display("FAIL abort_partial_count: got %0d required 1", word_count); end
        rx_valid = 1'b1;
        rx_data  = 8'hAA;
        q.delete();
        q = {8'hEF, 8'hBE, 8'hAD, 8'hDE};
        load(1, 1'b0);
        n_checks++;
        if (word_count !== 11'd1) begin n_fail++; $display("FAIL abort_count: got %0d required 1", word_count); end
        address = 32'h0; #1;
        n_checks++;
        if (instruction !== 32'hDEADBEEF) begin n_fail++; $display("FAIL abort_mem0: got %h required deadbeef", instruction); end
        check_mem();
    endtask

    task automatic test_reset_mid();
        do_start();
        send_byte(8'h03);
        send_byte(8'h00);
        for (int k = 0; k < 3; k++) send_byte(8'($urandom));
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_checks++;
        if ({rx_ready, cpu_stall, prog_done, prog_err} !== 4'b0000 || word_count !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: ready/stall/done/err=%b count=%0d required 0000 0",
                     {rx_ready, cpu_stall, prog_done, prog_err}, word_count);
        end
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        n_checks++;
        if (rx_ready !== 1'b0 || cpu_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_idle: ready=%b stall=%b required 0 0", rx_ready, cpu_stall);
        end
        check_mem();
        fill_random(1);
        load(1, 1'b1);
        check_mem();
    endtask

    task automatic test_random();
        repeat (6) begin
            int len;
            len = $urandom_range(1, 6);
            fill_random(len);
            load(len, 1'b1);
            check_mem();
        end
    endtask

    task automatic test_back_to_back();
        fill_random(5);
        load(5, 1'b0);
        fill_random(2);
        load(2, 1'b0);
        n_checks++;
        if (word_count !== 11'd2) begin n_fail++; $display("FAIL b2b_count: got %0d required 2", word_count); end
        check_mem();
    endtask

    initial begin
        for (int i = 0; i < MEM_DEPTH; i++) m_vld[i] = 1'b0;
        test_reset();
        test_spec_load();
        test_fetch_range();
        test_full_depth();
        test_len_overflow();
        test_abort();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
